argmax_unit: RTL
================

Name: argmax_unit

Overview:
- Downstream consumer of the 10-entry signed 32-bit layer-4 output memory (mm4_memory) in the FPGA demo.
- On `start`, it walks every address of that memory through its registered read port and tracks the signed maximum.
- It reports the winning class index and value, then pulses `done`.
- Final stage of inference; its result drives board LEDs/HEX.

Parameters:
- NUM_CLASSES, 10, number of logits scanned (addresses 0..NUM_CLASSES-1)
- DATA_WIDTH, 32, signed logit width (matches memory `data_out`)
- ADDR_WIDTH, 16, memory read-address width
- IDX_WIDTH, 4, width of class index output; must satisfy 2^IDX_WIDTH >= NUM_CLASSES

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- start  in  1  begin scan; sampled only in IDLE
- read_addr  out  ADDR_WIDTH  address to memory read port (registered)
- data_in  in  DATA_WIDTH  signed memory `data_out`; equals mem[read_addr] one clk edge after `read_addr` is presented
- busy  out  1  high from accepted start until done cycle inclusive
- done  out  1  one-cycle pulse, result valid
- max_index  out  IDX_WIDTH  winning class index, held until next done
- max_value  out  DATA_WIDTH  signed winning logit, held until next done

Behaviour:
- **Clocking and reset.** Single clock. Reset is asynchronous, active-low `resetn`.
- **Reset values.** While `resetn`=0: read_addr=0, busy=0, done=0, max_index=0, max_value=0, state=IDLE, all internal counters and best registers 0.
- **States:** IDLE, SCAN, FINISH.
- **IDLE.**
  - `start`=1 at edge E0: state->SCAN, read_addr<=0, issue counter<=1, busy<=1.
  - `start`=0: remain in IDLE.
- **SCAN, address issue.**
  - Each edge, read_addr increments by 1 until it reaches NUM_CLASSES-1, then holds.
  - No address >= NUM_CLASSES is ever driven.
- **SCAN, capture pipeline.**
  - A 2-deep valid/index shift tracks read latency: address k is presented from edge E_k, memory registers at E_{k+1}, unit samples `data_in` at E_{k+2}.
- **Compare rule.**
  - The first captured sample (k=0) unconditionally loads best_val/best_idx.
  - Later samples replace the best only if data_in > best_val, using a full-width signed compare.
  - Ties keep the lower index.
- **Transition to FINISH.** At E_{NUM_CLASSES+1}, after the k=NUM_CLASSES-1 capture, state->FINISH. At that same edge:
  - max_index<=final best_idx and max_value<=final best_val, including when the last sample wins.
  - done<=1.
- **FINISH.** One cycle with done=1 and busy=1. Next edge: done<=0, busy<=0, state->IDLE.
- **Latency.** For NUM_CLASSES=10, `done` is high in the cycle after edge E11 (12th clk after start sampled).
- **start handling.**
  - `start` in SCAN or FINISH is ignored: no restart, no queuing.
  - `start` on the edge after FINISH (state IDLE) is accepted, giving back-to-back operation with one idle cycle minimum.
- **Output stability.** max_index/max_value change only at the done edge; previous results stay visible during a new scan.
- **Reset mid-scan.** Immediate return to reset values; no done is emitted; the partial result is discarded.
- **Arithmetic.** No arithmetic on data, compare only; index counters are IDX_WIDTH wide and never wrap.

Optional Feature:
- Macro: ARGMAX_HEX_DISPLAY_EN.
- **Defined:**
  - Adds output port `hex_out` (7 bits, active-low segments, DE1-SoC HEX order {g,f,e,d,c,b,a}) decoding max_index 0..9, registered, reset value 7'b1000000 ("0").
  - Indices >= 10 show all segments off (7'b1111111).
- **Undefined:** port and decoder are absent; all other behaviour is identical.

Decomposition:
- **Shared package nn_pkg:**
  - NN_DATA_WIDTH=32, NN_ADDR_WIDTH=16, NN_NUM_CLASSES=10, NN_IDX_WIDTH=4.
  - argmax state encoding constants (IDLE=2'd0, SCAN=2'd1, FINISH=2'd2).
  - Seven-segment digit constants.
- **Sub-module:** seven_seg_decoder (combinational 4-bit -> 7-bit), instantiated only under ARGMAX_HEX_DISPLAY_EN.
- The core FSM/compare stays in argmax_unit.

Test Plan:
1. Bench model of mm4_memory (posedge registered read) preloaded [5,-3,12,7,0,12,-100,1,2,3]; start pulse -> done exactly 12 clks later, max_index=2 (tie with idx5 keeps lower), max_value=12, read_addr sequence 0..9 then held.
2. All-negative [-10,-4,-9,-50,-7,-8,-11,-12,-13,-14] -> max_index=1, max_value=-4 (proves signed compare, first-sample load).
3. Entries 0..8 = 32'h80000000, entry 9 = 32'h7FFFFFFF -> max_index=9, max_value=32'h7FFFFFFF (last-sample/extreme values).
4. start re-pulsed at cycles 3 and 7 of a scan -> single done, result unchanged; separate run with resetn=0 at cycle 5 -> all outputs 0 at once, no done; new start afterwards -> correct result.
5. Back-to-back: first run result idx2/12, memory reloaded with idx6=99, start on first IDLE cycle after done -> max_index/max_value hold 2/12 until second done, then 6/99.
6. With ARGMAX_HEX_DISPLAY_EN: result index 7 -> hex_out=7'b1111000; after reset -> 7'b1000000.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared constants for the NN demo datapath: layer geometry, argmax FSM
// state encoding and active-low seven-segment digit patterns.
package nn_pkg;

    localparam int NN_DATA_WIDTH  = 32;
    localparam int NN_ADDR_WIDTH  = 16;
    localparam int NN_NUM_CLASSES = 10;
    localparam int NN_IDX_WIDTH   = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_FINISH = 2'd2
    } argmax_state_e;

    // Segment order {g,f,e,d,c,b,a}, a 0 lights the segment.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational decimal digit to active-low seven-segment pattern.
// Values 10..15 blank the display.
module seven_seg_decoder
    import nn_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        unique case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/argmax_unit.sv
// Scans the layer-4 logit memory through its registered read port and reports
// the signed maximum and its index. Optional ARGMAX_HEX_DISPLAY_EN adds hex_out.
module argmax_unit
    import nn_pkg::*;
#(
    parameter int NUM_CLASSES = NN_NUM_CLASSES,
    parameter int DATA_WIDTH  = NN_DATA_WIDTH,
    parameter int ADDR_WIDTH  = NN_ADDR_WIDTH,
    parameter int IDX_WIDTH   = NN_IDX_WIDTH
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         start,
    output logic [ADDR_WIDTH-1:0]        read_addr,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    output logic                         busy,
    output logic                         done,
    output logic [IDX_WIDTH-1:0]         max_index,
    output logic signed [DATA_WIDTH-1:0] max_value
`ifdef ARGMAX_HEX_DISPLAY_EN
    ,
    output logic [6:0]                   hex_out
`endif
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

    argmax_state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0]        read_addr_q, read_addr_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic [IDX_WIDTH-1:0]         max_index_q, max_index_d;
    logic signed [DATA_WIDTH-1:0] max_value_q, max_value_d;

    // Two-stage latency tracker: iss_* is the address on the port now,
    // cap_* is the address whose data is on data_in now.
    logic                         iss_v_q, iss_v_d;
    logic [IDX_WIDTH-1:0]         iss_idx_q, iss_idx_d;
    logic                         cap_v_q, cap_v_d;
    logic [IDX_WIDTH-1:0]         cap_idx_q, cap_idx_d;
    logic signed [DATA_WIDTH-1:0] best_val_q, best_val_d;
    logic [IDX_WIDTH-1:0]         best_idx_q, best_idx_d;

    logic                         take_sample;
    logic signed [DATA_WIDTH-1:0] next_best_val;
    logic [IDX_WIDTH-1:0]         next_best_idx;
    logic [IDX_WIDTH-1:0]         iss_idx_inc;

    always_comb begin
        // NOTE: every _d starts as its _q so no path leaves a signal unassigned,
        // which would otherwise infer a latch.
        state_d     = state_q;
        read_addr_d = read_addr_q;
        busy_d      = busy_q;
        done_d      = done_q;
        max_index_d = max_index_q;
        max_value_d = max_value_q;
        iss_v_d     = iss_v_q;
        iss_idx_d   = iss_idx_q;
        cap_v_d     = cap_v_q;
        cap_idx_d   = cap_idx_q;
        best_val_d  = best_val_q;
        best_idx_d  = best_idx_q;

        // Strict greater-than keeps the lower index on ties.
        take_sample   = cap_v_q && ((cap_idx_q == '0) || (data_in > best_val_q));
        next_best_val = take_sample ? data_in   : best_val_q;
        next_best_idx = take_sample ? cap_idx_q : best_idx_q;
        iss_idx_inc   = iss_idx_q + IDX_WIDTH'(1);

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_SCAN;
                    read_addr_d = '0;
                    busy_d      = 1'b1;
                    iss_v_d     = 1'b1;
                    iss_idx_d   = '0;
                    cap_v_d     = 1'b0;
                end
            end

            ST_SCAN: begin
                cap_v_d    = iss_v_q;
                cap_idx_d  = iss_idx_q;
                best_val_d = next_best_val;
                best_idx_d = next_best_idx;

                if (iss_v_q && (iss_idx_q != LAST_IDX)) begin
                    iss_idx_d   = iss_idx_inc;
                    read_addr_d = ADDR_WIDTH'(iss_idx_inc);
                end else begin
                    iss_v_d = 1'b0;
                end

                if (cap_v_q && (cap_idx_q == LAST_IDX)) begin
                    state_d     = ST_FINISH;
                    cap_v_d     = 1'b0;
                    max_index_d = next_best_idx;
                    max_value_d = next_best_val;
                    done_d      = 1'b1;
                end
            end

            ST_FINISH: begin
                state_d = ST_IDLE;
                done_d  = 1'b0;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                done_d  = 1'b0;
                busy_d  = 1'b0;
                iss_v_d = 1'b0;
                cap_v_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!resetn) begin
            state_q     <= ST_IDLE;
            read_addr_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            max_index_q <= '0;
            max_value_q <= '0;
            iss_v_q     <= 1'b0;
            iss_idx_q   <= '0;
            cap_v_q     <= 1'b0;
            cap_idx_q   <= '0;
            best_val_q  <= '0;
            best_idx_q  <= '0;
        end else begin
            state_q     <= state_d;
            read_addr_q <= read_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            max_index_q <= max_index_d;
            max_value_q <= max_value_d;
            iss_v_q     <= iss_v_d;
            iss_idx_q   <= iss_idx_d;
            cap_v_q     <= cap_v_d;
            cap_idx_q   <= cap_idx_d;
            best_val_q  <= best_val_d;
            best_idx_q  <= best_idx_d;
        end
    end

    assign read_addr = read_addr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign max_index = max_index_q;
    assign max_value = max_value_q;

`ifdef ARGMAX_HEX_DISPLAY_EN
    logic [6:0] hex_d, hex_q;

    // Decode the next index so the display updates on the same edge as max_index.
    seven_seg_decoder u_hex (
        .digit (4'(max_index_d)),
        .seg   (hex_d)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) hex_q <= SEG_0;
        else         hex_q <= hex_d;
    end

    assign hex_out = hex_q;
`endif

endmodule
